seg7_scan: RTL and testbench



---
 rtl/seg7_scan.sv | 109 ++++++++++
 tb/tb_seg7_scan.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : 4-digit common-anode hex display scanner with frame-synchronous
//            updates, per-slot anode dead-time and leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seg7_scan #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        data_we,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n
);

    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   P_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0]   P_BLANK = PW'(BLANK);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          w_tick;
    logic          w_boundary;
    logic [3:0]    w_nibble;
    logic [15:0]   w_upper;
    logic          w_blank;
    logic [6:0]    w_glyph;

    assign w_tick     = (p_q == P_LAST);
    assign w_boundary = w_tick && (d_q == 2'd3);

    always_comb begin
        p_d       = w_tick ? '0 : p_q + 1'b1;
        d_d       = w_tick ? d_q + 2'd1 : d_q;
        shadow_d  = data_we ? data_in : shadow_q;
        disp_d    = (w_boundary && pending_q) ? shadow_q : disp_q;
        // A write landing on the boundary re-arms pending for the next frame.
        pending_d = data_we ? 1'b1 : (w_boundary ? 1'b0 : pending_q);
    end

    assign w_nibble = disp_q[{d_q, 2'b00} +: 4];
    assign w_upper  = disp_q >> {d_q, 2'b00};
    assign w_blank  = blank_lz && (d_q != 2'd0) && (w_upper == 16'h0000);

    always_comb begin
        case (w_nibble)
            4'h0: w_glyph = 7'h40;
            4'h1: w_glyph = 7'h79;
            4'h2: w_glyph = 7'h24;
            4'h3: w_glyph = 7'h30;
            4'h4: w_glyph = 7'h19;
            4'h5: w_glyph = 7'h12;
            4'h6: w_glyph = 7'h02;
            4'h7: w_glyph = 7'h78;
            4'h8: w_glyph = 7'h00;
            4'h9: w_glyph = 7'h10;
            4'hA: w_glyph = 7'h08;
            4'hB: w_glyph = 7'h03;
            4'hC: w_glyph = 7'h46;
            4'hD: w_glyph = 7'h21;
            4'hE: w_glyph = 7'h06;
            default: w_glyph = 7'h0E;
        endcase
    end

    always_comb begin
        an_d = 4'hF;
        if ((p_q >= P_BLANK) && !w_blank) begin
            an_d[d_q] = 1'b0;
        end
        seg_d = w_blank ? 7'h7F : w_glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= '0;
            d_q       <= 2'd0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= 4'hF;
        end else begin
            p_q       <= p_d;
            d_q       <= d_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Self-checking bench for seg7_scan against a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic        data_we  = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    int total = 0;
    int bad   = 0;

    // Reference model: slot position derived purely from cycles since reset.
    int          mc;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    bit          m_pend;
    logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_we  (data_we),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            assert (an_n inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})
                else $error("an_n not one-hot-low: %h", an_n);
        end
    end

    function automatic void m_reset();
        mc       = 0;
        m_shadow = 16'h0000;
        m_disp   = 16'h0000;
        m_pend   = 1'b0;
    endfunction

    // Predicts the outputs loaded on the coming edge, advances the model, then
    // waits until just after that edge.
    task automatic step(output logic [3:0] ea, output logic [6:0] es,
                        output int pp, output int pd);
        int  p;
        int  d;
        bit  blank;
        p     = mc % DIV;
        d     = (mc / DIV) % 4;
        blank = 1'b0;
        if (blank_lz && d >= 1) begin
            blank = 1'b1;
            for (int k = d; k < 4; k++) begin
                if (m_disp[4*k +: 4] != 4'h0) blank = 1'b0;
            end
        end
        ea = 4'hF;
        if (p >= BLANK && !blank) ea[d] = 1'b0;
        es = blank ? 7'h7F : dec[m_disp[4*d +: 4]];
        if (p == DIV - 1 && d == 3 && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (data_we) begin
            m_shadow = data_in;
            m_pend   = 1'b1;
        end
        mc++;
        pp = p;
        pd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_we = i[0];
            data_in = 16'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (an_n !== 4'hF || seg_n !== 7'h7F) begin
                bad++;
                $display("FAIL reset_hold an_n=%h seg_n=%h expected an_n=F seg_n=7F", an_n, seg_n);
            end
        end
        data_we = 1'b0;
        rst_n   = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            step(ea, es, pp, pd);
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL reset_release an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
            if (i == 2) begin
                total++;
                if (an_n !== 4'hE || seg_n !== 7'h40) begin
                    bad++;
                    $display("FAIL first_anode an_n=%h seg_n=%h expected an_n=E seg_n=40", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_frame_update();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        bit crossed;
        logic [6:0] want_seg [4] = '{7'h0E, 7'h24, 7'h08, 7'h79};
        logic [3:0] want_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        blank_lz = 1'b0;
        while (mc % FRAME != DIV + 3) begin
            step(ea, es, pp, pd);
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL frame_idle an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
        end
        data_in = 16'h1A2F;
        data_we = 1'b1;
        crossed = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(ea, es, pp, pd);
            data_we = 1'b0;
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL frame_update an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
            if (crossed && pp == DIV - 1) begin
                total++;
                if (an_n !== want_an[pd] || seg_n !== want_seg[pd]) begin
                    bad++;
                    $display("FAIL frame_digit%0d an_n=%h seg_n=%h expected an_n=%h seg_n=%h",
                             pd, an_n, seg_n, want_an[pd], want_seg[pd]);
                end
            end
            if (pp == DIV - 1 && pd == 3) crossed = ~crossed;
        end
    endtask

    task automatic test_collision();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        while (mc % FRAME != FRAME - 5) begin
            step(ea, es, pp, pd);
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL collision_idle an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
        end
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            data_we = (i == 0) || (i == 4);
            data_in = (i == 0) ? 16'h1111 : 16'h2222;
            step(ea, es, pp, pd);
            data_we = 1'b0;
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL collision an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
            if (i == 5 + DIV - 1 || i == 5 + FRAME + DIV - 1) begin
                total++;
                if (seg_n !== ((i < FRAME) ? 7'h79 : 7'h24)) begin
                    bad++;
                    $display("FAIL collision_word seg_n=%h expected %h", seg_n, (i < FRAME) ? 7'h79 : 7'h24);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        data_in  = 16'h0030;
        data_we  = 1'b1;
        blank_lz = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 2 * FRAME) blank_lz = 1'b0;
            step(ea, es, pp, pd);
            data_we = 1'b0;
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL blanking lz=%0d an_n=%h seg_n=%h expected an_n=%h seg_n=%h",
                         blank_lz, an_n, seg_n, ea, es);
            end
        end
    endtask

    task automatic test_deadtime();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        blank_lz = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            data_we = ($urandom % 5 == 0);
            data_in = 16'($urandom);
            step(ea, es, pp, pd);
            total++;
            if ((an_n === 4'hF) != (pp < BLANK)) begin
                bad++;
                $display("FAIL deadtime p=%0d an_n=%h expected off=%0d", pp, an_n, pp < BLANK);
            end
        end
        data_we = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int i = 0; i < 6 * FRAME; i++) begin
            data_we = ($urandom % 7 == 0);
            data_in = 16'($urandom) & masks[$urandom % 5];
            if ($urandom % 11 == 0) blank_lz = ~blank_lz;
            step(ea, es, pp, pd);
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL random an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
        end
        data_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea;
        logic [6:0] es;
        int pp, pd;
        blank_lz = 1'b0;
        while (mc % FRAME != 2 * DIV + 4) begin
            data_we = (mc % FRAME == DIV + 1);
            data_in = 16'hBEEF;
            step(ea, es, pp, pd);
            data_we = 1'b0;
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL midreset_pre an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
        end
        rst_n = 1'b0;
        #2;
        total++;
        if (an_n !== 4'hF || seg_n !== 7'h7F) begin
            bad++;
            $display("FAIL midreset_async an_n=%h seg_n=%h expected an_n=F seg_n=7F", an_n, seg_n);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(ea, es, pp, pd);
            total++;
            if (an_n !== ea || seg_n !== es) begin
                bad++;
                $display("FAIL midreset_post an_n=%h seg_n=%h expected an_n=%h seg_n=%h", an_n, seg_n, ea, es);
            end
            if (pp == DIV - 1) begin
                total++;
                if (seg_n !== 7'h40) begin
                    bad++;
                    $display("FAIL midreset_discard seg_n=%h expected 40", seg_n);
                end
            end
        end
    endtask

    initial begin
        m_reset();
        #1;
        test_reset();
        test_frame_update();
        test_collision();
        test_blanking();
        test_deadtime();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
